// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with buffered LSU results
// into one registered register-file write port, and tracks destinations of
// issued long-latency ops so decode can stall on operands still in flight.
module writeback_arbiter #(
    parameter int DEPTH = 2  // LSU buffer entries; the pointer logic assumes exactly 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_value,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_value,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  check_rs1,
    input  logic [4:0]  check_rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rf_write_enable,
    output logic [4:0]  rf_write_select,
    output logic [31:0] rf_write_value,
    output logic [1:0]  lsu_count
);

    // LSU buffer state: two entries, one-bit pointers wrap naturally modulo 2.
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [4:0]  buf_rd_q  [DEPTH];
    logic [31:0] buf_val_q [DEPTH];

    // Pending-write scoreboard; bit 0 is kept at zero so x0 never reads busy.
    logic [31:0] busy_q, busy_d;

    // Output register to the register file.
    logic        wen_q, wen_d;
    logic [4:0]  wsel_q, wsel_d;
    logic [31:0] wval_q, wval_d;

    // Arbitration results.
    logic        lsu_xfer;
    logic        push, pop;
    logic        win_valid, win_lsu;
    logic [4:0]  win_rd;
    logic [31:0] win_val;

    // Ready looks only at current occupancy; a same-cycle pop does not open a slot.
    assign lsu_ready = (count_q < 2'(DEPTH));
    assign lsu_xfer  = lsu_valid && lsu_ready;

    // Pick the winner (ALU > buffer head > bypassed LSU) and decide push/pop.
    always_comb begin
        win_valid = 1'b0;
        win_lsu   = 1'b0;
        win_rd    = 5'd0;
        win_val   = 32'd0;
        push      = 1'b0;
        pop       = 1'b0;
        if (alu_valid) begin
            win_valid = 1'b1;
            win_rd    = alu_rd;
            win_val   = alu_value;
            push      = lsu_xfer;
        end else if (count_q != 2'd0) begin
            win_valid = 1'b1;
            win_lsu   = 1'b1;
            win_rd    = buf_rd_q[rd_ptr_q];
            win_val   = buf_val_q[rd_ptr_q];
            pop       = 1'b1;
            push      = lsu_xfer;
        end else if (lsu_xfer) begin
            win_valid = 1'b1;
            win_lsu   = 1'b1;
            win_rd    = lsu_rd;
            win_val   = lsu_value;
        end
    end

    // Buffer bookkeeping: occupancy and pointer advance.
    always_comb begin
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    end

    // Scoreboard next state: clear on LSU writeback, then set on issue so set wins.
    always_comb begin
        busy_d = busy_q;
        if (win_lsu) begin
            busy_d[win_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Output register next state: x0 writes are consumed but never enabled.
    always_comb begin
        wen_d  = 1'b0;
        wsel_d = wsel_q;
        wval_d = wval_q;
        if (win_valid) begin
            wen_d  = (win_rd != 5'd0);
            wsel_d = win_rd;
            wval_d = win_val;
        end
    end

    // Control and output state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            busy_q   <= 32'd0;
            wen_q    <= 1'b0;
            wsel_q   <= 5'd0;
            wval_q   <= 32'd0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            busy_q   <= busy_d;
            wen_q    <= wen_d;
            wsel_q   <= wsel_d;
            wval_q   <= wval_d;
        end
    end

    // Buffer payload storage; contents are meaningless while count says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_rd_q[wr_ptr_q]  <= lsu_rd;
            buf_val_q[wr_ptr_q] <= lsu_value;
        end
    end

    assign rs1_busy        = (check_rs1 != 5'd0) && busy_q[check_rs1];
    assign rs2_busy        = (check_rs2 != 5'd0) && busy_q[check_rs2];
    assign rf_write_enable = wen_q;
    assign rf_write_select = wsel_q;
    assign rf_write_value  = wval_q;
    assign lsu_count       = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: a behavioural model computes the
// expected write for each cycle, queues it, and compares after the clock edge.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_value;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_value;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  check_rs1;
    logic [4:0]  check_rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_write_enable;
    logic [4:0]  rf_write_select;
    logic [31:0] rf_write_value;
    logic [1:0]  lsu_count;

    always #5 clk = ~clk;

    writeback_arbiter #(.DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_value       (alu_value),
        .lsu_valid       (lsu_valid),
        .lsu_ready       (lsu_ready),
        .lsu_rd          (lsu_rd),
        .lsu_value       (lsu_value),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .check_rs1       (check_rs1),
        .check_rs2       (check_rs2),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .rf_write_enable (rf_write_enable),
        .rf_write_select (rf_write_select),
        .rf_write_value  (rf_write_value),
        .lsu_count       (lsu_count)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
    } ent_t;

    typedef struct packed {
        logic        en;
        logic [4:0]  sel;
        logic [31:0] val;
    } exp_t;

    // Reference model state.
    ent_t        mq[$];
    exp_t        expq[$];
    logic [31:0] mbusy;
    logic [4:0]  m_sel;
    logic [31:0] m_val;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic model_busy(input logic [4:0] idx);
        return (idx != 5'd0) && mbusy[idx];
    endfunction

    // One clock cycle: drive at negedge, check combinational outputs, predict the
    // registered write, then compare after the posedge. Returns whether the LSU
    // offer was accepted.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] aval,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] lval,
                         input logic iv, input logic [4:0] ird, output logic took);
        ent_t        e;
        exp_t        x;
        int          sz;
        logic        ready, bypass, win, lsu_win;
        logic [4:0]  wrd;
        logic [31:0] wval;
        alu_valid   = av;
        alu_rd      = ard;
        alu_value   = aval;
        lsu_valid   = lv;
        lsu_rd      = lrd;
        lsu_value   = lval;
        issue_valid = iv;
        issue_rd    = ird;
        #1;
        sz    = mq.size();
        ready = (sz < 2);
        check_eq("lsu_ready", 32'(lsu_ready), 32'(ready));
        check_eq("lsu_count", 32'(lsu_count), 32'(sz));
        check_eq("rs1_busy", 32'(rs1_busy), 32'(model_busy(check_rs1)));
        check_eq("rs2_busy", 32'(rs2_busy), 32'(model_busy(check_rs2)));
        took    = lv && ready;
        bypass  = !av && (sz == 0) && took;
        win     = 1'b0;
        lsu_win = 1'b0;
        wrd     = 5'd0;
        wval    = 32'd0;
        if (av) begin
            win = 1'b1; wrd = ard; wval = aval;
        end else if (sz > 0) begin
            e = mq.pop_front();
            win = 1'b1; lsu_win = 1'b1; wrd = e.rd; wval = e.val;
        end else if (bypass) begin
            win = 1'b1; lsu_win = 1'b1; wrd = lrd; wval = lval;
        end
        if (took && !bypass) mq.push_back('{rd: lrd, val: lval});
        if (win) begin
            m_sel = wrd;
            m_val = wval;
        end
        x.en  = win && (wrd != 5'd0);
        x.sel = m_sel;
        x.val = m_val;
        expq.push_back(x);
        if (lsu_win) mbusy[wrd] = 1'b0;
        if (iv) mbusy[ird] = 1'b1;
        mbusy[0] = 1'b0;
        $display("t=%0t alu=%0b/%0d/%08h lsu=%0b/%0d/%08h took=%0b issue=%0b/%0d -> exp en=%0b sel=%0d val=%08h cnt=%0d",
                 $time, av, ard, aval, lv, lrd, lval, took, iv, ird, x.en, x.sel, x.val, mq.size());
        @(posedge clk);
        #1;
        x = expq.pop_front();
        check_eq("wr_enable", 32'(rf_write_enable), 32'(x.en));
        check_eq("wr_select", 32'(rf_write_select), 32'(x.sel));
        check_eq("wr_value", rf_write_value, x.val);
        check_eq("count_post", 32'(lsu_count), 32'(mq.size()));
        check_eq("rs1_busy_post", 32'(rs1_busy), 32'(model_busy(check_rs1)));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic t;
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, t);
    endtask

    task automatic model_reset();
        mq.delete();
        expq.delete();
        mbusy = 32'd0;
        m_sel = 5'd0;
        m_val = 32'd0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_en"},    32'(rf_write_enable), 32'd0);
        check_eq({tag, "_sel"},   32'(rf_write_select), 32'd0);
        check_eq({tag, "_val"},   rf_write_value, 32'd0);
        check_eq({tag, "_count"}, 32'(lsu_count), 32'd0);
        check_eq({tag, "_ready"}, 32'(lsu_ready), 32'd1);
        check_eq({tag, "_rs1"},   32'(rs1_busy), 32'd0);
    endtask

    // Hard bound on total run time.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic    t;
        logic [4:0] offers[$];
        logic [4:0] o;
        alu_valid = 0; alu_rd = 0; alu_value = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_value = 0;
        issue_valid = 0; issue_rd = 0;
        check_rs1 = 5'd0; check_rs2 = 5'd0;
        model_reset();
        rst_n = 1'b0;
        #2;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ALU only, then idle: enable drops, select/value hold.
        cycle(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, t);
        idle(1);

        // ALU write to x0 is dropped.
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, t);
        // LSU x0 buffered behind the ALU, then popped with enable low.
        cycle(1'b1, 5'd6, 32'h00000066, 1'b1, 5'd0, 32'hDEAD0000, 1'b0, 5'd0, t);
        check_eq("x0_took", 32'(t), 32'd1);
        idle(2);

        // Scoreboard: issue rd7, stall visible until LSU writeback clears it.
        check_rs1 = 5'd7;
        check_rs2 = 5'd0;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, t);
        idle(2);
        check_eq("rs1_busy_7", 32'(rs1_busy), 32'd1);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0, t);
        idle(1);

        // Contention: ALU busy 4 cycles while LSU offers rd 1,2,3.
        check_rs1 = 5'd2;
        offers = '{5'd1, 5'd2, 5'd3};
        for (int i = 0; i < 10; i++) begin
            o = (offers.size() > 0) ? offers[0] : 5'd0;
            cycle(i < 4, 5'(10 + i), 32'hA000_0000 + 32'(i), offers.size() > 0, o,
                  32'hB000_0000 + 32'(o), 1'b0, 5'd0, t);
            if (t) void'(offers.pop_front());
        end
        check_eq("offers_drained", 32'(offers.size()), 32'd0);

        // Set beats clear for the same rd in the same cycle.
        check_rs1 = 5'd9;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, t);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99999999, 1'b1, 5'd9, t);
        check_eq("rs1_busy_9", 32'(rs1_busy), 32'd1);
        idle(1);

        // Fill buffer to 2 with rd4 pending, then reset mid-cycle.
        check_rs1 = 5'd4;
        cycle(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, 1'b1, 5'd4, t);
        cycle(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23, 1'b0, 5'd0, t);
        check_eq("pre_rst_count", 32'(lsu_count), 32'd2);
        check_eq("pre_rst_en", 32'(rf_write_enable), 32'd1);
        check_eq("pre_rst_busy4", 32'(rs1_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h0BADF00D, 1'b0, 5'd0, t);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
